spike_pulse_arbiter: RTL
========================

Name: spike_pulse_arbiter

Overview:
- Round-robin scheduler that shares one pulse line between N_REQ spike requesters (neuron outputs).
- Each granted request produces exactly one pulse of cfg_width clocks, then a mandatory low gap of cfg_gap clocks.
- Drives the shared xbit pulse/inverter path in the neuron array in place of a free-running pulse generator.
- Reports which requester owns each pulse.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- CNT_W, 8, width of the width/gap configuration fields and of the internal counter.
- ID_W, $clog2(N_REQ), width of pulse_id.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  when 0, no new grants are issued; an in-flight pulse or gap still completes.
- req  input  N_REQ  level requests; requester i holds req[i] high until it sees ack[i].
- cfg_width  input  CNT_W  pulse high time in clocks; 0 is treated as 1.
- cfg_gap  input  CNT_W  low time after the pulse in clocks; 0 means no gap state.
- ack  output  N_REQ  one-hot, one-cycle acknowledge on the cycle a pulse starts.
- pulse_out  output  1  shared pulse line.
- pulse_id  output  ID_W  index of the current or most recent owner.
- busy  output  1  high in PULSE and GAP.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge):
  - state=IDLE; ack=0, pulse_out=0, pulse_id=0, busy=0.
  - Round-robin pointer rr=0; counter=0.
  - rst overrides everything, including mid-pulse: pulse_out drops on the next edge, the pulse is truncated, and no ack is reissued.
- IDLE:
  - If enable=1 and req!=0 at the edge, grant the first set bit searching upward from rr and wrapping at N_REQ.
  - On the grant: ack[g]=1 for exactly that cycle, pulse_out=1, pulse_id=g, busy=1, rr=(g+1) mod N_REQ.
  - Latch the counter to max(cfg_width,1)-1 and latch cfg_gap; go to PULSE.
  - Otherwise stay in IDLE with all outputs low (pulse_id holds its value).
  - Latency: req sampled high at edge k gives pulse_out=1 and ack after edge k.
- PULSE:
  - pulse_out=1. While counter!=0, decrement.
  - At counter==0, drop pulse_out on the next edge.
  - If the latched gap==0, go to IDLE (busy=0).
  - Otherwise load counter=gap-1 and go to GAP.
- GAP:
  - pulse_out=0, busy=1. Decrement each cycle; at counter==0 go to IDLE (busy=0).
- Timing guarantees:
  - pulse_out is high for exactly max(cfg_width,1) cycles.
  - There are at least gap+1 low cycles between consecutive pulses, because arbitration occupies the IDLE cycle.
- Config changes while busy have no effect on the current pulse; they apply at the next grant.
- req changes while busy are ignored until IDLE. A requester that drops req before it is granted loses its slot with no side effects.
- Simultaneous requests: exactly one ack per grant. All N requesters held high are served in order rr, rr+1, … with no starvation.
- Pointer wrap: after a grant to N_REQ-1, rr=0.
- The counter never underflows. Max width is 2^CNT_W-1 cycles; cfg_width=0 behaves exactly like cfg_width=1.
- enable falling during PULSE/GAP finishes the sequence, then the block stays in IDLE. enable rising in IDLE with pending req grants on that edge.

Test Plan:
- Reset, then req=4'b0001, width=3, gap=2 → ack[0] one cycle after the sampling edge; pulse_out high 3 cycles; busy high 5 cycles; pulse_id=0.
- req=4'b1111 held, each ack dropping only its own bit, width=1, gap=0 → grants 0,1,2,3 in that order; pulse_out pattern 1,0,1,0,…; exactly 4 acks, all one-hot.
- rr=3 after grants to 0,1,2, then req=4'b1001 → grant 3 first, then 0 (wrap-around).
- cfg_width=0, gap=0, req[2] → single 1-cycle pulse, pulse_id=2.
- During a width=5 pulse, change cfg_width to 2 and raise enable=0 → current pulse still 5 cycles; no further grant while enable=0; enable=1 with pending req → next pulse is 2 cycles.
- rst asserted on the 2nd cycle of a width=6 pulse → pulse_out, busy, ack=0 after that edge; rr=0; a following req=4'b0110 grants 1.

Source files
------------

// File: rtl/spike_pulse_arbiter.sv
// Round-robin arbiter sharing one pulse line between spike requesters.
// Each grant emits one pulse of cfg_width clocks followed by a cfg_gap low gap.
module spike_pulse_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  output logic [N_REQ-1:0] ack,
  output logic             pulse_out,
  output logic [ID_W-1:0]  pulse_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  id_d;
  logic [N_REQ-1:0] ack_d;
  logic             gnt_found;
  logic [ID_W-1:0]  gnt_idx;
  int               idx;

  // first set request at or above rr, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_q) + i) % N_REQ;
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    id_d    = pulse_id;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && gnt_found) begin
          ack_d[gnt_idx] = 1'b1;
          id_d    = gnt_idx;
          rr_d    = ID_W'((int'(gnt_idx) + 1) % N_REQ);
          cnt_d   = (cfg_width == '0) ? '0
                  : cfg_width - CNT_W'(1);
          gap_d   = cfg_gap;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = gap_q - CNT_W'(1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      rr_q      <= '0;
      ack       <= '0;
      pulse_out <= 1'b0;
      pulse_id  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      rr_q      <= rr_d;
      ack       <= ack_d;
      pulse_out <= (state_d == PULSE);
      pulse_id  <= id_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule
